// File: rtl/cpu_seq_pkg.sv
// -----------------------------------------------------------------------------
// cpu_seq_pkg
//
// Shared definitions for the execution sequencer of the single-cycle MIPS
// datapath.
//
// Contents:
//   seq_state_e  - sequencer state encoding. It is also visible on the
//                  top-level 'state' port: 0=RUN, 1=WAIT_IN, 2=HALTED.
//   SW_WIDTH     - number of user switches that feed the IN write-back.
//   DATA_WIDTH   - width of the datapath words handled by the sequencer.
//   zext_sw()    - zero-extends the switch bank to a datapath word.
// -----------------------------------------------------------------------------
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_IN = 2'd1,
        ST_HALTED  = 2'd2
    } seq_state_e;

    localparam int SW_WIDTH   = 18;
    localparam int DATA_WIDTH = 32;

    // Switch values enter the register file as unsigned words.
    function automatic logic [DATA_WIDTH-1:0] zext_sw(input logic [SW_WIDTH-1:0] sw);
        return {{(DATA_WIDTH - SW_WIDTH){1'b0}}, sw};
    endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Conditions a raw, asynchronous push-button into a clean one-cycle press
// pulse.
//   1. A 2-FF synchroniser brings the raw level into the clk_i domain.
//   2. The debounced level follows the synchronised level only after the two
//      have disagreed for DEBOUNCE_CYCLES consecutive cycles. Any agreement in
//      between restarts the count, so short glitches are discarded.
//   3. A rising edge of the debounced level produces press_o for exactly one
//      cycle.
//
// Parameters:
//   DEBOUNCE_CYCLES - cycles of stable disagreement needed to accept a new
//                     level (>= 1).
//
// Ports:
//   clk_i   in   1  clock
//   rst_i   in   1  asynchronous, active-high reset; clears every flop
//   btn_i   in   1  raw button level, active-high
//   press_o out  1  one-cycle pulse on each accepted press
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    // The counter only has to reach DEBOUNCE_CYCLES-1. At least one bit is
    // kept so that DEBOUNCE_CYCLES=1 still elaborates.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             deb_q;
    logic             deb_d;
    logic             deb_dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sync_level;

    assign sync_level = sync_q[1];

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync_level == deb_q) begin
            // Agreement restarts the stability window.
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // This is the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
            deb_d = sync_level;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
        end
    end

    assign press_o = deb_q & ~deb_dly_q;

endmodule

// File: rtl/cpu_exec_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_exec_sequencer
//
// Execution controller for the single-cycle MIPS datapath. It replaces a
// free-running divided clock with a registered, one-CLK-wide commit enable
// (cpu_en). The PC, register file and RAM advance only on edges where
// cpu_en=1.
//
// An advance event is a divider tick in free-run mode or a debounced step
// press in single-step mode. An event is acted on only in RUN and only while
// cpu_en=0. If an event lands in the commit cycle, the control flags still
// describe the instruction being committed, so acting on it would commit that
// instruction twice.
//
// Behaviour on an accepted event:
//   - HALT: the sequencer stops for good and waits for reset.
//   - IN:   the sequencer stalls until the user presses insert, latches SW into
//           user_input and commits on the same edge.
//   - OUT:  out_data is captured for the display on the same edge that raises
//           cpu_en.
//
// Parameters:
//   DIV_COUNT       - CLK cycles between free-run advance events (>= 2).
//   DEBOUNCE_CYCLES - button stability window in cycles (>= 1).
//
// Ports:
//   CLK           in   1   system clock
//   reset         in   1   asynchronous, active-high reset
//   run_mode      in   1   1 = free run, 0 = single step
//   step_btn      in   1   raw step button
//   insert_btn    in   1   raw insert button
//   halt          in   1   current instruction is HALT
//   input_flag    in   1   current instruction is IN
//   output_flag   in   1   current instruction is OUT
//   SW            in   18  user switches
//   out_data      in   32  register value for OUT
//   cpu_en        out  1   one-cycle commit pulse
//   user_input    out  32  value supplied for the IN write-back
//   display_value out  32  last committed OUT value
//   display_valid out  1   at least one OUT has been committed
//   state         out  2   0=RUN, 1=WAIT_IN, 2=HALTED
//   instr_count   out  32  number of cpu_en pulses issued (wraps)
// -----------------------------------------------------------------------------
module cpu_exec_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int DIV_COUNT       = 25000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  run_mode,
    input  logic                  step_btn,
    input  logic                  insert_btn,
    input  logic                  halt,
    input  logic                  input_flag,
    input  logic                  output_flag,
    input  logic [SW_WIDTH-1:0]   SW,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic                  cpu_en,
    output logic [DATA_WIDTH-1:0] user_input,
    output logic [DATA_WIDTH-1:0] display_value,
    output logic                  display_valid,
    output logic [1:0]            state,
    output logic [DATA_WIDTH-1:0] instr_count
);

    localparam int TICK_W = $clog2(DIV_COUNT);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(DIV_COUNT - 1);

    // -------------------------------------------------------------------------
    // Button conditioning
    // -------------------------------------------------------------------------
    logic step_press;
    logic insert_press;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk_i   (CLK),
        .rst_i   (reset),
        .btn_i   (step_btn),
        .press_o (step_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_insert_debounce (
        .clk_i   (CLK),
        .rst_i   (reset),
        .btn_i   (insert_btn),
        .press_o (insert_press)
    );

    // -------------------------------------------------------------------------
    // Free-run divider. The counter is held at zero in step mode, so switching
    // back to free run always starts a full DIV_COUNT period.
    // -------------------------------------------------------------------------
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;
    logic              tick;

    always_comb begin
        tick = run_mode && (tick_q == TICK_MAX);
        if (!run_mode || (tick_q == TICK_MAX)) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM and its output registers
    // -------------------------------------------------------------------------
    seq_state_e            state_q;
    seq_state_e            state_d;
    logic                  cpu_en_q;
    logic                  cpu_en_d;
    logic [DATA_WIDTH-1:0] user_input_q;
    logic [DATA_WIDTH-1:0] user_input_d;
    logic [DATA_WIDTH-1:0] display_value_q;
    logic [DATA_WIDTH-1:0] display_value_d;
    logic                  display_valid_q;
    logic                  display_valid_d;
    logic [DATA_WIDTH-1:0] instr_count_q;
    logic [DATA_WIDTH-1:0] instr_count_d;
    logic                  adv_event;
    logic                  adv_valid;

    // step_press is ignored in free-run mode, and ticks are ignored in step mode.
    assign adv_event = run_mode ? tick : step_press;
    assign adv_valid = adv_event && !cpu_en_q;

    always_comb begin
        state_d         = state_q;
        cpu_en_d        = 1'b0;       // the commit pulse lasts one cycle
        user_input_d    = user_input_q;
        display_value_d = display_value_q;
        display_valid_d = display_valid_q;

        case (state_q)
            ST_RUN: begin
                if (adv_valid) begin
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else if (input_flag) begin
                        state_d = ST_WAIT_IN;
                    end else begin
                        cpu_en_d = 1'b1;
                        if (output_flag) begin
                            display_value_d = out_data;
                            display_valid_d = 1'b1;
                        end
                    end
                end
            end

            ST_WAIT_IN: begin
                // user_input changes on the same edge that raises cpu_en, so
                // it is already stable for the whole commit cycle.
                if (insert_press) begin
                    user_input_d = zext_sw(SW);
                    cpu_en_d     = 1'b1;
                    state_d      = ST_RUN;
                end
            end

            ST_HALTED: begin
                // Only reset leaves this state.
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        instr_count_d = instr_count_q + DATA_WIDTH'(cpu_en_q);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q         <= ST_RUN;
            cpu_en_q        <= 1'b0;
            user_input_q    <= '0;
            display_value_q <= '0;
            display_valid_q <= 1'b0;
            instr_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            cpu_en_q        <= cpu_en_d;
            user_input_q    <= user_input_d;
            display_value_q <= display_value_d;
            display_valid_q <= display_valid_d;
            instr_count_q   <= instr_count_d;
        end
    end

    assign cpu_en        = cpu_en_q;
    assign user_input    = user_input_q;
    assign display_value = display_value_q;
    assign display_valid = display_valid_q;
    assign state         = state_q;
    assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_cpu_exec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_exec_sequencer
//
// Directed and randomized checks of cpu_exec_sequencer with DIV_COUNT=4 and
// DEBOUNCE_CYCLES=3. Inputs are driven and outputs sampled 1 time unit after
// each rising CLK edge. The expected commit count, the display contents and the
// press/no-press outcomes come from a small reference model built from the
// sequencer's rules: one commit every DIV_COUNT cycles in free run, and a
// press accepted only if it is held for at least DEBOUNCE_CYCLES cycles.
// -----------------------------------------------------------------------------
module tb_cpu_exec_sequencer;
    import cpu_seq_pkg::*;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        run_mode = 1'b0;
    logic        step_btn = 1'b0;
    logic        insert_btn = 1'b0;
    logic        halt = 1'b0;
    logic        input_flag = 1'b0;
    logic        output_flag = 1'b0;
    logic [17:0] SW = '0;
    logic [31:0] out_data = '0;
    logic        cpu_en;
    logic [31:0] user_input;
    logic [31:0] display_value;
    logic        display_valid;
    logic [1:0]  state;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] exp_cnt;
    logic [31:0] exp_disp;
    logic        exp_valid;

    always #5 CLK = ~CLK;

    cpu_exec_sequencer #(
        .DIV_COUNT       (DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .run_mode      (run_mode),
        .step_btn      (step_btn),
        .insert_btn    (insert_btn),
        .halt          (halt),
        .input_flag    (input_flag),
        .output_flag   (output_flag),
        .SW            (SW),
        .out_data      (out_data),
        .cpu_en        (cpu_en),
        .user_input    (user_input),
        .display_value (display_value),
        .display_valid (display_valid),
        .state         (state),
        .instr_count   (instr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick1();
            if (cpu_en) pulses++;
        end
    endtask

    // Waits for the next cpu_en pulse, up to 'bound' cycles.
    task automatic wait_en(input int bound, output int cycles);
        cycles = 0;
        do begin
            tick1();
            cycles++;
        end while (!cpu_en && cycles < bound);
    endtask

    // Holds a button for len cycles, then releases it for gap cycles, counting
    // commits. The values seen in the first commit cycle are returned.
    task automatic push(input bit ins, input int len, input int gap, output int pulses,
                        output int first_at, output logic [31:0] ui_at, output logic [1:0] st_at);
        pulses = 0;
        first_at = 0;
        ui_at = '0;
        st_at = '0;
        if (ins) insert_btn = 1'b1;
        else     step_btn = 1'b1;
        for (int i = 1; i <= len + gap; i++) begin
            if (i == len + 1) begin
                insert_btn = 1'b0;
                step_btn = 1'b0;
            end
            tick1();
            if (cpu_en) begin
                pulses++;
                if (first_at == 0) begin
                    first_at = i;
                    ui_at = user_input;
                    st_at = state;
                end
            end
        end
        insert_btn = 1'b0;
        step_btn = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
        check({tag, "_user_input"}, user_input, 32'd0);
        check({tag, "_display_value"}, display_value, 32'd0);
        check({tag, "_display_valid"}, 32'(display_valid), 32'd0);
        check({tag, "_state"}, 32'(state), 32'(ST_RUN));
        check({tag, "_instr_count"}, instr_count, 32'd0);
    endtask

    // Called right after reset is released in free-run mode with all flags low:
    // commits are expected in cycles DIV+1, 2*DIV+1 and 3*DIV+1.
    task automatic free_run_pattern(input string tag);
        for (int k = 1; k <= 13; k++) begin
            tick1();
            check({tag, "_en"}, 32'(cpu_en), 32'(k % DIV == 0));
            check({tag, "_state"}, 32'(state), 32'(ST_RUN));
        end
        check({tag, "_count"}, instr_count, 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, f, c, len, total;
        logic [31:0] ui;
        logic [1:0]  st;
        logic        oflag;
        logic [31:0] odata;

        // ---- Reset state, then free run ----
        reset = 1'b1;
        run_mode = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("rst");
        reset = 1'b0;
        free_run_pattern("fr");
        exp_cnt = 32'd3;
        exp_disp = '0;
        exp_valid = 1'b0;

        // ---- OUT capture on the tick edge ----
        output_flag = 1'b1;
        out_data = 32'hDEADBEEF;
        tick1();
        check("out_pre1_valid", 32'(display_valid), 32'd0);
        tick1();
        check("out_pre2_valid", 32'(display_valid), 32'd0);
        check("out_pre2_en", 32'(cpu_en), 32'd0);
        tick1();
        check("out_en", 32'(cpu_en), 32'd1);
        check("out_value", display_value, 32'hDEADBEEF);
        check("out_valid", 32'(display_valid), 32'd1);
        check("out_count", instr_count, exp_cnt);
        exp_cnt++;
        exp_disp = 32'hDEADBEEF;
        exp_valid = 1'b1;
        output_flag = 1'b0;
        out_data = 32'h12345678;
        wait_en(2 * DIV, c);
        check("hold_interval", 32'(c), 32'(DIV));
        check("hold_value", display_value, exp_disp);
        check("hold_count", instr_count, exp_cnt);
        exp_cnt++;

        // ---- Randomized free run against the model ----
        for (int i = 0; i < 16; i++) begin
            oflag = 1'($urandom_range(0, 1));
            odata = $urandom;
            output_flag = oflag;
            out_data = odata;
            wait_en(2 * DIV, c);
            check("rnd_interval", 32'(c), 32'(DIV));
            check("rnd_en", 32'(cpu_en), 32'd1);
            if (oflag) begin
                exp_disp = odata;
                exp_valid = 1'b1;
            end
            check("rnd_display", display_value, exp_disp);
            check("rnd_valid", 32'(display_valid), 32'(exp_valid));
            check("rnd_count", instr_count, exp_cnt);
            exp_cnt++;
        end
        output_flag = 1'b0;

        // ---- Switching to step mid-period clears the divider ----
        tick1();
        tick1();
        run_mode = 1'b0;
        run(3, p);
        check("mode_step_pulses", 32'(p), 32'd0);
        run_mode = 1'b1;
        wait_en(2 * DIV, c);
        check("mode_restart_interval", 32'(c), 32'(DIV));
        check("mode_restart_count", instr_count, exp_cnt);
        exp_cnt++;

        // ---- Step mode ----
        run_mode = 1'b0;
        run(20, p);
        check("step_idle_pulses", 32'(p), 32'd0);
        push(1'b0, 10, 20, p, f, ui, st);
        check("step_pulses", 32'(p), 32'd1);
        check("step_latency_ok", 32'(f >= 1 && f <= 7), 32'd1);
        exp_cnt++;
        check("step_count", instr_count, exp_cnt);
        push(1'b0, 1, 15, p, f, ui, st);
        check("glitch_pulses", 32'(p), 32'd0);
        for (int i = 0; i < 8; i++) begin
            len = $urandom_range(1, 6);
            push(1'b0, len, 15, p, f, ui, st);
            check("rnd_step_pulses", 32'(p), 32'(len >= DEB));
            if (len >= DEB) exp_cnt++;
            check("rnd_step_count", instr_count, exp_cnt);
        end
        push(1'b1, 6, 15, p, f, ui, st);
        check("insert_in_run_pulses", 32'(p), 32'd0);
        check("insert_in_run_state", 32'(state), 32'(ST_RUN));

        // ---- IN stall ----
        input_flag = 1'b1;
        SW = 18'h2ABCD;
        push(1'b0, 5, 15, p, f, ui, st);
        check("in_enter_pulses", 32'(p), 32'd0);
        check("in_state", 32'(state), 32'(ST_WAIT_IN));
        run(50, p);
        check("in_stall_pulses", 32'(p), 32'd0);
        push(1'b0, 5, 15, p, f, ui, st);
        check("in_step_ignored", 32'(p), 32'd0);
        run_mode = 1'b1;
        run(20, p);
        check("in_tick_ignored", 32'(p), 32'd0);
        run_mode = 1'b0;
        check("in_state_held", 32'(state), 32'(ST_WAIT_IN));
        push(1'b1, 10, 15, p, f, ui, st);
        check("in_insert_pulses", 32'(p), 32'd1);
        check("in_user_input_at_en", ui, 32'h0002ABCD);
        check("in_state_at_en", 32'(st), 32'(ST_RUN));
        exp_cnt++;
        check("in_count", instr_count, exp_cnt);
        input_flag = 1'b0;
        SW = 18'h3FFFF;
        run(5, p);
        check("in_user_input_hold", user_input, 32'h0002ABCD);

        // ---- Async reset from WAIT_IN ----
        input_flag = 1'b1;
        SW = 18'h15555;
        push(1'b0, 5, 15, p, f, ui, st);
        check("arst_pre_state", 32'(state), 32'(ST_WAIT_IN));
        check("arst_pre_user_input", user_input, 32'h0002ABCD);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("arst");
        input_flag = 1'b0;
        run_mode = 1'b1;
        @(posedge CLK);
        #1;
        reset = 1'b0;
        free_run_pattern("fr2");
        exp_cnt = 32'd3;

        // ---- HALT ----
        halt = 1'b1;
        c = 0;
        total = 0;
        do begin
            tick1();
            c++;
            if (cpu_en) total++;
        end while (state != 2'(ST_HALTED) && c < 2 * DIV);
        check("halt_state", 32'(state), 32'(ST_HALTED));
        push(1'b0, 5, 20, p, f, ui, st);
        total += p;
        push(1'b1, 5, 20, p, f, ui, st);
        total += p;
        run_mode = 1'b0;
        push(1'b0, 5, 20, p, f, ui, st);
        total += p;
        push(1'b1, 5, 20, p, f, ui, st);
        total += p;
        check("halt_pulses", 32'(total), 32'd0);
        check("halt_state_held", 32'(state), 32'(ST_HALTED));
        check("halt_count_frozen", instr_count, exp_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
